// File: rtl/pc_gen.sv
// Program counter generator for an in-order fetch front end.
// Owns the fetch address, the previously accepted fetch address and a single
// pending redirect slot used while instruction memory is back-pressuring.
// Redirects (trap, jal, branch, jalr) are aligned to IALIGN before use; a
// misaligned request is reported with a one-cycle target_misaligned pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// BOOT      | first cycle after reset, no fetch request issued yet
// RUN       | fetching; sequential advance or direct redirect on accept
// WAIT_PEND | a redirect arrived while imem stalled; target held in pend

module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            next_sel,
    input  logic            branch_result,
    input  logic            jalr,
    input  logic [XLEN-1:0] next_address,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            load,
    input  logic            dmem_valid,
    input  logic            imem_ready,
    output logic [XLEN-1:0] address_out,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pre_address_pc,
    output logic            target_misaligned
);

    // Low address bits that must be zero for a legal fetch target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        WAIT_PEND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] pend_nxt;
    logic [XLEN-1:0] addr_nxt;
    logic [XLEN-1:0] pre_nxt;
    logic            fv_nxt;
    logic            tm_nxt;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            redirect;
    logic            accept;
    logic            lstall;

    assign redirect = trap | next_sel | branch_result | jalr;
    assign accept   = fetch_valid & imem_ready;
    assign lstall   = load & ~dmem_valid;

    // Select and align the redirect target; jalr drops bit 0 before the alignment check.
    always_comb begin
        raw_target = trap ? trap_vector : next_address;
        if (!trap && jalr) begin
            raw_target[0] = 1'b0;
        end
        misaligned = |(raw_target & ALIGN_MASK);
        target     = raw_target & ~ALIGN_MASK;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:      state_nxt = RUN;
            RUN:       if (redirect && !accept) state_nxt = WAIT_PEND;
            WAIT_PEND: if (accept) state_nxt = RUN;
            default:   state_nxt = BOOT;
        endcase
    end

    // Next values for the registered outputs and the pending slot.
    always_comb begin
        addr_nxt = address_out;
        pre_nxt  = pre_address_pc;
        pend_nxt = pend;
        fv_nxt   = (state_nxt != BOOT);
        tm_nxt   = 1'b0;
        case (state)
            RUN: begin
                tm_nxt = redirect & misaligned;
                if (redirect && accept) begin
                    addr_nxt = target;
                    pre_nxt  = address_out;
                end else if (redirect) begin
                    pend_nxt = target;
                end else if (!lstall && accept) begin
                    addr_nxt = address_out + STEP;
                    pre_nxt  = address_out;
                end
            end
            WAIT_PEND: begin
                tm_nxt = redirect & misaligned;
                // A redirect arriving in the accept cycle is the freshest target and wins.
                if (redirect) begin
                    pend_nxt = target;
                end
                if (accept) begin
                    addr_nxt = redirect ? target : pend;
                    pre_nxt  = address_out;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            address_out       <= RESET_VECTOR;
            pre_address_pc    <= RESET_VECTOR;
            fetch_valid       <= 1'b0;
            target_misaligned <= 1'b0;
            pend              <= '0;
        end else begin
            address_out       <= addr_nxt;
            pre_address_pc    <= pre_nxt;
            fetch_valid       <= fv_nxt;
            target_misaligned <= tm_nxt;
            pend              <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with constant expectations, then random
// traffic. A reference model predicts outputs each clock into a scoreboard
// queue; a monitor pops and compares one entry per cycle.

module tb_pc_gen;

    localparam int          IALIGN = 4;
    localparam logic [31:0] RV     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_sel = 1'b0;
    logic        branch_result = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] next_address = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        load = 1'b0;
    logic        dmem_valid = 1'b0;
    logic        imem_ready = 1'b1;
    logic [31:0] address_out;
    logic        fetch_valid;
    logic [31:0] pre_address_pc;
    logic        target_misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] p;
        logic        v;
        logic        t;
    } exp_t;

    exp_t sb_q[$];

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(IALIGN)) dut (
        .clk               (clk),
        .rst               (rst),
        .next_sel          (next_sel),
        .branch_result     (branch_result),
        .jalr              (jalr),
        .next_address      (next_address),
        .trap              (trap),
        .trap_vector       (trap_vector),
        .load              (load),
        .dmem_valid        (dmem_valid),
        .imem_ready        (imem_ready),
        .address_out       (address_out),
        .fetch_valid       (fetch_valid),
        .pre_address_pc    (pre_address_pc),
        .target_misaligned (target_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: pc/prev registers, a queue holding at most one pending
    // redirect, and "fetching" meaning the boot cycle is over.
    logic [31:0]     m_pc = RV;
    logic [31:0]     m_prev = RV;
    logic            m_fetching = 1'b0;
    logic            m_tm = 1'b0;
    logic [31:0]     m_pend[$];

    always @(posedge clk) begin
        logic [31:0] tgt;
        logic        redir;
        exp_t        e;
        if (rst) begin
            m_pc = RV;
            m_prev = RV;
            m_fetching = 1'b0;
            m_tm = 1'b0;
            m_pend.delete();
        end else if (!m_fetching) begin
            m_fetching = 1'b1;
            m_tm = 1'b0;
        end else begin
            redir = trap | next_sel | branch_result | jalr;
            tgt = trap ? trap_vector : next_address;
            if (!trap && jalr) tgt = tgt - (tgt % 2);
            m_tm = redir && ((tgt % IALIGN) != 0);
            tgt = tgt - (tgt % IALIGN);
            if (m_pend.size() != 0) begin
                if (redir) m_pend[0] = tgt;
                if (imem_ready) begin
                    m_prev = m_pc;
                    m_pc = m_pend.pop_front();
                end
            end else if (redir) begin
                if (imem_ready) begin
                    m_prev = m_pc;
                    m_pc = tgt;
                end else begin
                    m_pend.push_back(tgt);
                end
            end else if (imem_ready && !(load && !dmem_valid)) begin
                m_prev = m_pc;
                m_pc = m_pc + 32'(IALIGN);
            end
        end
        e.a = m_pc;
        e.p = m_prev;
        e.v = m_fetching;
        e.t = m_tm;
        sb_q.push_back(e);
    end

    // Monitor: one scoreboard entry per clock, compared after outputs settle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_address_out", address_out, e.a);
                chk("sb_pre_address_pc", pre_address_pc, e.p);
                chk("sb_fetch_valid", 32'(fetch_valid), 32'(e.v));
                chk("sb_target_misaligned", 32'(target_misaligned), 32'(e.t));
            end
        end
    end

    task automatic clear_ctl();
        next_sel = 1'b0;
        branch_result = 1'b0;
        jalr = 1'b0;
        trap = 1'b0;
        load = 1'b0;
        dmem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_a[5];
        logic        exp_v[5];
        int          sel;
        exp_a = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset release and sequential fetch.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("boot_address_out", address_out, exp_a[i]);
            chk("boot_fetch_valid", 32'(fetch_valid), 32'(exp_v[i]));
            @(negedge clk);
        end

        // Branch taken from 0x10.
        chk("br_start_pc", address_out, 32'h10);
        branch_result = 1'b1;
        next_address = 32'h40;
        @(negedge clk);
        chk("br_address_out", address_out, 32'h40);
        chk("br_pre_address_pc", pre_address_pc, 32'h10);

        // jal to 0x20, then stall with jalr then trap overwriting the pending slot.
        branch_result = 1'b0;
        next_sel = 1'b1;
        next_address = 32'h20;
        @(negedge clk);
        chk("jal_address_out", address_out, 32'h20);
        next_sel = 1'b0;
        imem_ready = 1'b0;
        jalr = 1'b1;
        next_address = 32'h81;
        @(negedge clk);
        chk("stall1_address_out", address_out, 32'h20);
        chk("jalr_bit0_no_misalign", 32'(target_misaligned), 32'h0);
        jalr = 1'b0;
        trap = 1'b1;
        trap_vector = 32'h100;
        @(negedge clk);
        chk("stall2_address_out", address_out, 32'h20);
        trap = 1'b0;
        @(negedge clk);
        chk("stall3_address_out", address_out, 32'h20);
        imem_ready = 1'b1;
        @(negedge clk);
        chk("pend_trap_address_out", address_out, 32'h100);
        chk("pend_trap_pre", pre_address_pc, 32'h20);

        // Load stall at 0x30.
        next_sel = 1'b1;
        next_address = 32'h30;
        @(negedge clk);
        chk("ld_start_pc", address_out, 32'h30);
        chk("ld_start_pre", pre_address_pc, 32'h100);
        next_sel = 1'b0;
        load = 1'b1;
        dmem_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("lstall_address_out", address_out, 32'h30);
            chk("lstall_pre_address_pc", pre_address_pc, 32'h100);
        end
        dmem_valid = 1'b1;
        @(negedge clk);
        chk("ld_done_address_out", address_out, 32'h34);
        chk("ld_done_pre", pre_address_pc, 32'h30);
        clear_ctl();

        // Misaligned jal target.
        next_sel = 1'b1;
        next_address = 32'h42;
        @(negedge clk);
        chk("mis_address_out", address_out, 32'h40);
        chk("mis_pulse", 32'(target_misaligned), 32'h1);
        next_sel = 1'b0;
        @(negedge clk);
        chk("mis_pulse_end", 32'(target_misaligned), 32'h0);
        chk("mis_next_pc", address_out, 32'h44);

        // Wrap at the top of the address space.
        next_sel = 1'b1;
        next_address = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_top", address_out, 32'hFFFF_FFFC);
        next_sel = 1'b0;
        @(negedge clk);
        chk("wrap_zero", address_out, 32'h0);

        // Reset during WAIT_PEND discards the pending target.
        imem_ready = 1'b0;
        next_sel = 1'b1;
        next_address = 32'h200;
        @(negedge clk);
        chk("wp_hold", address_out, 32'h0);
        next_sel = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wp_rst_address_out", address_out, RV);
        chk("wp_rst_fetch_valid", 32'(fetch_valid), 32'h0);
        rst = 1'b0;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("wp_rst_first_fetch", address_out, RV);
        @(negedge clk);
        chk("wp_rst_no_pending", address_out, RV + 32'd4);

        // Random traffic, checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            clear_ctl();
            rst = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 7);
            next_sel = (sel == 1);
            branch_result = (sel == 2);
            jalr = (sel == 3);
            trap = ($urandom_range(0, 15) == 0);
            next_address = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC);
            trap_vector = ($urandom_range(0, 1) == 0) ? $urandom() : 32'h0000_0800;
            load = ($urandom_range(0, 3) == 0);
            dmem_valid = $urandom_range(0, 1) == 1;
            imem_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        clear_ctl();
        rst = 1'b0;
        imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
